// File: rtl/usbf_pkt_tx.sv
`default_nettype none
// ============================================================================
// usbf_pkt_tx : USB 2.0 device packet transmitter (handshake / PID+payload+CRC16) on 8-bit UTMI
// Revision 1.0
// ============================================================================
module usbf_pkt_tx #(
    parameter int MAX_PAYLOAD = 512,
    parameter int CNT_W       = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [3:0]       req_pid_i,
    input  logic             req_zlp_i,
    input  logic [7:0]       tx_data_i,
    input  logic             tx_data_valid_i,
    input  logic             tx_data_last_i,
    output logic             tx_data_ready_o,
    output logic [7:0]       utmi_data_o,
    output logic             utmi_txvalid_o,
    input  logic             utmi_txready_i,
    output logic             tx_busy_o,
    output logic             tx_done_o,
    output logic             tx_err_o,
    output logic [CNT_W-1:0] tx_count_o
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PAYLOAD);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PID    = 3'd1,
        S_DATA   = 3'd2,
        S_CRC_LO = 3'd3,
        S_CRC_HI = 3'd4
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [3:0]       pid;
    logic             zlp;
    logic [15:0]      crc;
    logic [CNT_W-1:0] count;
    logic             done;
    logic             err;
    logic             accept;
    logic             abort;
    logic             finish;
    logic [7:0]       data_out;

    // Reflected CRC16 (poly 0xA001), one full byte per call, LSB first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] c_in, input logic [7:0] d);
        logic [15:0] c;
        c = c_in ^ {8'h00, d};
        for (int i = 0; i < 8; i++) begin
            if (c[0]) c = (c >> 1) ^ 16'hA001;
            else      c = c >> 1;
        end
        return c;
    endfunction

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        abort      = 1'b0;
        finish     = 1'b0;
        data_out   = 8'h00;
        case (state)
            S_IDLE: begin
                if (req_valid_i) next_state = S_PID;
            end
            S_PID: begin
                data_out = {~pid, pid};
                if (utmi_txready_i) begin
                    if (pid[1:0] != 2'b11) begin
                        next_state = S_IDLE;
                        finish     = 1'b1;
                    end else if (zlp) begin
                        next_state = S_CRC_LO;
                    end else begin
                        next_state = S_DATA;
                    end
                end
            end
            S_DATA: begin
                data_out = tx_data_i;
                if (utmi_txready_i) begin
                    // Underrun or a byte beyond the payload limit truncates the packet.
                    if (!tx_data_valid_i || (count == MAX_CNT && !tx_data_last_i)) begin
                        abort      = 1'b1;
                        next_state = S_IDLE;
                    end else begin
                        accept = 1'b1;
                        if (tx_data_last_i) next_state = S_CRC_LO;
                    end
                end
            end
            S_CRC_LO: begin
                data_out = ~crc[7:0];
                if (utmi_txready_i) next_state = S_CRC_HI;
            end
            S_CRC_HI: begin
                data_out = ~crc[15:8];
                if (utmi_txready_i) begin
                    next_state = S_IDLE;
                    finish     = 1'b1;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            pid   <= 4'h0;
            zlp   <= 1'b0;
            crc   <= 16'hFFFF;
            count <= '0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= next_state;
            done  <= finish;
            err   <= abort;
            if (state == S_IDLE && req_valid_i) begin
                pid   <= req_pid_i;
                zlp   <= req_zlp_i;
                crc   <= 16'hFFFF;
                count <= '0;
            end
            if (accept) begin
                crc   <= crc16_byte(crc, tx_data_i);
                count <= count + 1'b1;
            end
        end
    end

    assign req_ready_o     = (state == S_IDLE);
    assign tx_busy_o       = (state != S_IDLE);
    assign utmi_txvalid_o  = (state != S_IDLE);
    assign utmi_data_o     = data_out;
    assign tx_data_ready_o = accept;
    assign tx_done_o       = done;
    assign tx_err_o        = err;
    assign tx_count_o      = count;

endmodule
`default_nettype wire

// File: tb/tb_usbf_pkt_tx.sv
`default_nettype none
// ============================================================================
// tb_usbf_pkt_tx : directed bench for usbf_pkt_tx (MAX_PAYLOAD reduced to 4)
// Revision 1.0
// ============================================================================
module tb_usbf_pkt_tx;

    localparam int CNT_W = 11;

    logic             clk;
    logic             rst_n;
    logic             req_valid;
    logic             req_ready;
    logic [3:0]       req_pid;
    logic             req_zlp;
    logic [7:0]       tx_data;
    logic             tx_data_valid;
    logic             tx_data_last;
    logic             tx_data_ready;
    logic [7:0]       utmi_data;
    logic             utmi_txvalid;
    logic             utmi_txready;
    logic             tx_busy;
    logic             tx_done;
    logic             tx_err;
    logic [CNT_W-1:0] tx_count;

    int checks   = 0;
    int failures = 0;

    usbf_pkt_tx #(.MAX_PAYLOAD(4), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready),
        .req_pid_i       (req_pid),
        .req_zlp_i       (req_zlp),
        .tx_data_i       (tx_data),
        .tx_data_valid_i (tx_data_valid),
        .tx_data_last_i  (tx_data_last),
        .tx_data_ready_o (tx_data_ready),
        .utmi_data_o     (utmi_data),
        .utmi_txvalid_o  (utmi_txvalid),
        .utmi_txready_i  (utmi_txready),
        .tx_busy_o       (tx_busy),
        .tx_done_o       (tx_done),
        .tx_err_o        (tx_err),
        .tx_count_o      (tx_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then let the next inputs settle before checking.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic byte_out(input string tag, input logic [7:0] exp);
        #1;
        chk({tag, "_txvalid"}, 32'(utmi_txvalid), 32'd1);
        chk({tag, "_data"}, 32'(utmi_data), 32'(exp));
    endtask

    task automatic request(input logic [3:0] pid, input logic zlp);
        req_valid = 1'b1;
        req_pid   = pid;
        req_zlp   = zlp;
        tick();
        req_valid = 1'b0;
    endtask

    initial begin
        rst_n         = 1'b0;
        req_valid     = 1'b0;
        req_pid       = 4'h0;
        req_zlp       = 1'b0;
        tx_data       = 8'h00;
        tx_data_valid = 1'b0;
        tx_data_last  = 1'b0;
        utmi_txready  = 1'b0;
        #23;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_txvalid", 32'(utmi_txvalid), 32'd0);
        chk("rst_busy", 32'(tx_busy), 32'd0);
        chk("rst_data", 32'(utmi_data), 32'd0);
        chk("rst_done_err", 32'({tx_done, tx_err}), 32'd0);
        chk("rst_count", 32'(tx_count), 32'd0);
        rst_n = 1'b1;
        tick();

        // ACK handshake
        utmi_txready = 1'b1;
        request(4'h2, 1'b0);
        byte_out("ack_pid", 8'hD2);
        chk("ack_ready_busy", 32'({req_ready, tx_busy}), 32'b01);
        tick();
        chk("ack_done", 32'(tx_done), 32'd1);
        chk("ack_txvalid_low", 32'(utmi_txvalid), 32'd0);
        chk("ack_req_ready", 32'(req_ready), 32'd1);
        chk("ack_count", 32'(tx_count), 32'd0);
        tick();
        chk("ack_done_pulse", 32'(tx_done), 32'd0);

        // ZLP DATA0
        request(4'h3, 1'b1);
        byte_out("zlp_pid", 8'hC3);
        tick();
        byte_out("zlp_crclo", 8'h00);
        tick();
        byte_out("zlp_crchi", 8'h00);
        tick();
        chk("zlp_done", 32'({tx_done, tx_err}), 32'b10);

        // DATA1 with one 0x00 byte, txready toggling
        tick();
        request(4'hB, 1'b0);
        utmi_txready = 1'b0;
        byte_out("d1_pid_hold", 8'h4B);
        tick();
        utmi_txready = 1'b1;
        byte_out("d1_pid", 8'h4B);
        tick();
        tx_data = 8'h00; tx_data_valid = 1'b1; tx_data_last = 1'b1;
        utmi_txready = 1'b0;
        byte_out("d1_pay_hold", 8'h00);
        chk("d1_pay_hold_rdy", 32'(tx_data_ready), 32'd0);
        tick();
        utmi_txready = 1'b1;
        byte_out("d1_pay", 8'h00);
        chk("d1_pay_rdy", 32'(tx_data_ready), 32'd1);
        tick();
        tx_data_valid = 1'b0; tx_data_last = 1'b0;
        utmi_txready = 1'b0;
        byte_out("d1_crclo_hold", 8'h40);
        tick();
        utmi_txready = 1'b1;
        byte_out("d1_crclo", 8'h40);
        tick();
        utmi_txready = 1'b0;
        byte_out("d1_crchi_hold", 8'hBF);
        tick();
        utmi_txready = 1'b1;
        byte_out("d1_crchi", 8'hBF);
        tick();
        chk("d1_done", 32'({tx_done, tx_err}), 32'b10);
        chk("d1_count", 32'(tx_count), 32'd1);

        // Underrun after two payload bytes
        tick();
        request(4'h3, 1'b0);
        byte_out("ur_pid", 8'hC3);
        tick();
        tx_data = 8'h01; tx_data_valid = 1'b1;
        byte_out("ur_b0", 8'h01);
        tick();
        tx_data = 8'h02;
        byte_out("ur_b1", 8'h02);
        tick();
        tx_data_valid = 1'b0;
        #1;
        chk("ur_gap_rdy", 32'(tx_data_ready), 32'd0);
        tick();
        chk("ur_txvalid_low", 32'(utmi_txvalid), 32'd0);
        chk("ur_err_done", 32'({tx_err, tx_done}), 32'b10);
        chk("ur_count", 32'(tx_count), 32'd2);
        tick();
        chk("ur_err_pulse", 32'(tx_err), 32'd0);

        // Oversize: fifth byte without last
        request(4'h3, 1'b0);
        byte_out("ov_pid", 8'hC3);
        tick();
        tx_data_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tx_data = 8'h10 + 8'(i);
            byte_out("ov_byte", 8'h10 + 8'(i));
            chk("ov_byte_rdy", 32'(tx_data_ready), 32'd1);
            tick();
        end
        tx_data = 8'h14;
        #1;
        chk("ov_fifth_rdy", 32'(tx_data_ready), 32'd0);
        tick();
        tx_data_valid = 1'b0;
        chk("ov_err_done", 32'({tx_err, tx_done}), 32'b10);
        chk("ov_count", 32'(tx_count), 32'd4);
        chk("ov_txvalid_low", 32'(utmi_txvalid), 32'd0);

        // Async reset mid-DATA, then a normal ACK
        tick();
        request(4'h3, 1'b0);
        tick();
        tx_data = 8'h20; tx_data_valid = 1'b1;
        byte_out("rs_byte", 8'h20);
        rst_n = 1'b0;
        #1;
        chk("rs_txvalid_async", 32'(utmi_txvalid), 32'd0);
        chk("rs_idle", 32'({req_ready, tx_busy}), 32'b10);
        tx_data_valid = 1'b0;
        tick();
        chk("rs_no_pulse", 32'({tx_done, tx_err}), 32'd0);
        rst_n = 1'b1;
        tick();
        request(4'h2, 1'b0);
        byte_out("rs_ack", 8'hD2);
        tick();
        chk("rs_ack_done", 32'(tx_done), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
